// File: rtl/sm_bus_pkg.sv
// Shared definitions for the snooping bus controller: MSI line states,
// pending-request encoding, per-CPU slot layout and controller FSM states.
package sm_bus_pkg;

  // MSI state of a cache line, as reported by each CPU-side controller.
  localparam logic [1:0] MSI_INVALID  = 2'b00;
  localparam logic [1:0] MSI_SHARED   = 2'b01;
  localparam logic [1:0] MSI_MODIFIED = 2'b10;

  // Kind of bus transaction a CPU is waiting for.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_RD   = 2'd1,
    REQ_WR   = 2'd2,
    REQ_INV  = 2'd3
  } req_type_e;

  // One pending slot per CPU: request kind plus a victim write-back flag.
  typedef struct packed {
    req_type_e rtype;
    logic      wb;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{rtype: REQ_NONE, wb: 1'b0};

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNOOP  = 3'd1,
    ST_WRBACK = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_DONE   = 3'd4
  } bus_state_e;

  // Collapse the simultaneous pulses of one CPU into a single request.
  // A write miss dominates a read miss, which dominates an upgrade.
  function automatic req_type_e encode_req(input logic write_miss,
                                           input logic read_miss,
                                           input logic inv_out);
    req_type_e r;
    r = REQ_NONE;
    if (write_miss)     r = REQ_WR;
    else if (read_miss) r = REQ_RD;
    else if (inv_out)   r = REQ_INV;
    return r;
  endfunction

endpackage

// File: rtl/sm_bus_ctrl_if.sv
// Bundle of signals between the CPU-side MSI controllers and the bus
// controller. The controller side uses the master modport.
//
// Handshake: writeMiss/readMiss/invalidateOut/writeBack are single-cycle
// request pulses (no ready; the controller always accepts into the CPU's
// pending slot, and flags protocolError if the slot is already occupied).
// grant is a single-cycle completion pulse for the CPU whose request just
// finished; fetch/invalidateIn are single-cycle snoop commands.
interface sm_bus_ctrl_if
  import sm_bus_pkg::*;
#(
  parameter int NUM_CPUS = 2,
  parameter int ID_W     = 2
);

  // CPU side -> controller
  logic [NUM_CPUS-1:0]   writeMiss;
  logic [NUM_CPUS-1:0]   readMiss;
  logic [NUM_CPUS-1:0]   writeBack;
  logic [NUM_CPUS-1:0]   invalidateOut;
  logic [2*NUM_CPUS-1:0] cpuState;

  // controller -> CPU side / memory
  logic [NUM_CPUS-1:0]   fetch;
  logic [NUM_CPUS-1:0]   invalidateIn;
  logic [NUM_CPUS-1:0]   grant;
  logic [ID_W-1:0]       grantedId;
  logic                  memRead;
  logic                  memWrite;
  logic                  busy;
  logic                  protocolError;

  // controller FSM state, exposed for observation
  bus_state_e            state_dbg;

  modport master (
    input  writeMiss, readMiss, writeBack, invalidateOut, cpuState,
    output fetch, invalidateIn, grant, grantedId, memRead, memWrite,
           busy, protocolError, state_dbg
  );

  modport slave (
    output writeMiss, readMiss, writeBack, invalidateOut, cpuState,
    input  fetch, invalidateIn, grant, grantedId, memRead, memWrite,
           busy, protocolError, state_dbg
  );

endinterface

// File: rtl/sm_bus_arbiter.sv
// Combinational round-robin pick: the first pending CPU found scanning
// upward from (ptr + 1) mod NUM_CPUS, wrapping around to ptr itself last.
module sm_bus_arbiter #(
  parameter int NUM_CPUS = 2,
  parameter int ID_W     = 2
) (
  input  logic [NUM_CPUS-1:0] pending,
  input  logic [ID_W-1:0]     ptr,
  output logic                valid,
  output logic [ID_W-1:0]     idx
);

  // Walk candidates from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_CPUS; k >= 1; k--) begin
      for (int j = 0; j < NUM_CPUS; j++) begin
        if (pending[j] && (j == ((int'(ptr) + k) % NUM_CPUS))) begin
          valid = 1'b1;
          idx   = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/sm_bus_ctrl.sv
// Snooping bus controller: captures per-CPU miss/upgrade/write-back pulses
// into pending slots, serves them round-robin, broadcasts snoop fetch and
// invalidate commands, sequences memory write-back/read and returns a
// completion grant to the requester.
module sm_bus_ctrl
  import sm_bus_pkg::*;
#(
  parameter int NUM_CPUS    = 2,
  parameter int MEM_LATENCY = 4,
  parameter int ID_W        = 2
) (
  input logic           clock,
  input logic           reset,
  sm_bus_ctrl_if.master bus
);

  localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  // Sequencing state
  bus_state_e          state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  req_type_e           type_q, type_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     rr_q, rr_d;

  // Per-CPU pending slots and sticky error
  slot_t               slot_q [NUM_CPUS];
  slot_t               slot_d [NUM_CPUS];
  logic                perr_q, perr_d;

  // Combinational helpers
  logic [NUM_CPUS-1:0] pending;
  logic                arb_valid;
  logic [ID_W-1:0]     arb_idx;
  req_type_e           arb_type;
  logic                req_wb;
  req_type_e           pulse_type;
  logic [NUM_CPUS-1:0] fetch_c, inv_c, grant_c;
  logic                mem_rd_c, mem_wr_c, busy_c;

  sm_bus_arbiter #(
    .NUM_CPUS (NUM_CPUS),
    .ID_W     (ID_W)
  ) u_arbiter (
    .pending (pending),
    .ptr     (rr_q),
    .valid   (arb_valid),
    .idx     (arb_idx)
  );

  // Pending vector seen by the arbiter.
  always_comb begin
    pending = '0;
    for (int j = 0; j < NUM_CPUS; j++) begin
      pending[j] = (slot_q[j].rtype != REQ_NONE);
    end
  end

  // Look up the arbiter winner's request type and the requester's wb flag.
  always_comb begin
    arb_type = REQ_NONE;
    req_wb   = 1'b0;
    for (int j = 0; j < NUM_CPUS; j++) begin
      if (arb_idx == ID_W'(j)) arb_type = slot_q[j].rtype;
      if (id_q == ID_W'(j))    req_wb   = slot_q[j].wb;
    end
  end

  // State register plus the per-transaction latches, round-robin pointer,
  // pending slots and error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      type_q  <= REQ_NONE;
      cnt_q   <= '0;
      rr_q    <= '0;
      perr_q  <= 1'b0;
      for (int j = 0; j < NUM_CPUS; j++) begin
        slot_q[j] <= SLOT_EMPTY;
      end
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      perr_q  <= perr_d;
      for (int j = 0; j < NUM_CPUS; j++) begin
        slot_q[j] <= slot_d[j];
      end
    end
  end

  // Next-state logic: selection, snoop outcome, latency counting, completion.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          id_d    = arb_idx;
          type_d  = arb_type;
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        // Owner data and requester victim share a single write-back.
        if (req_wb || (|fetch_c)) begin
          state_d = ST_WRBACK;
          cnt_d   = CNT_LOAD;
        end else if (type_q == REQ_INV) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MEMRD;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WRBACK: begin
        if (cnt_q == '0) begin
          if (type_q == REQ_INV) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_MEMRD;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_MEMRD: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        rr_d    = id_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs plus the snoop broadcast, which follows the live
  // cpuState of every cache other than the requester.
  always_comb begin
    fetch_c  = '0;
    inv_c    = '0;
    grant_c  = '0;
    mem_rd_c = (state_q == ST_MEMRD);
    mem_wr_c = (state_q == ST_WRBACK);
    busy_c   = (state_q != ST_IDLE);
    for (int j = 0; j < NUM_CPUS; j++) begin
      if ((state_q == ST_SNOOP) && (id_q != ID_W'(j))) begin
        case (type_q)
          REQ_RD: begin
            fetch_c[j] = (bus.cpuState[2*j +: 2] == MSI_MODIFIED);
          end
          REQ_WR: begin
            inv_c[j]   = 1'b1;
            fetch_c[j] = (bus.cpuState[2*j +: 2] == MSI_MODIFIED);
          end
          REQ_INV: begin
            inv_c[j] = 1'b1;
          end
          default: ;
        endcase
      end
      if ((state_q == ST_DONE) && (id_q == ID_W'(j))) begin
        grant_c[j] = 1'b1;
      end
    end
  end

  // Slot capture: completion clears, snoop invalidate turns a pending
  // upgrade into a full write miss, then new pulses load or raise an error.
  always_comb begin
    perr_d     = perr_q;
    pulse_type = REQ_NONE;
    for (int j = 0; j < NUM_CPUS; j++) begin
      slot_d[j] = slot_q[j];
      if ((state_q == ST_DONE) && (id_q == ID_W'(j))) begin
        slot_d[j] = SLOT_EMPTY;
      end
      if ((state_q == ST_SNOOP) && inv_c[j] && (slot_d[j].rtype == REQ_INV)) begin
        slot_d[j].rtype = REQ_WR;
      end
      pulse_type = encode_req(bus.writeMiss[j], bus.readMiss[j],
                              bus.invalidateOut[j]);
      if (pulse_type != REQ_NONE) begin
        if (slot_d[j].rtype == REQ_NONE) begin
          slot_d[j].rtype = pulse_type;
          slot_d[j].wb    = slot_d[j].wb | bus.writeBack[j];
        end else begin
          perr_d = 1'b1;
        end
      end else if (bus.writeBack[j]) begin
        slot_d[j].wb = 1'b1;
      end
    end
  end

  assign bus.fetch         = fetch_c;
  assign bus.invalidateIn  = inv_c;
  assign bus.grant         = grant_c;
  assign bus.grantedId     = id_q;
  assign bus.memRead       = mem_rd_c;
  assign bus.memWrite      = mem_wr_c;
  assign bus.busy          = busy_c;
  assign bus.protocolError = perr_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_sm_bus_ctrl.sv
// Directed bench for sm_bus_ctrl (NUM_CPUS=2, MEM_LATENCY=4): a cycle table
// of inputs and expected outputs, then hand-written fairness and
// error/reset sequences.
module tb_sm_bus_ctrl;
  import sm_bus_pkg::*;

  localparam int N   = 2;
  localparam int L   = 4;
  localparam int IDW = 2;
  localparam logic [1:0] Z = 2'b00;

  typedef struct packed {
    logic [1:0] wm, rm, wbk, io;
    logic [3:0] cs;
  } in_t;

  typedef struct packed {
    logic [1:0] fe, ii, gr;
    logic       mr, mw, busy;
    logic [1:0] gid;
    logic       perr;
  } out_t;

  typedef struct packed {
    logic [3:0] tst;
    in_t        i;
    out_t       o;
  } vec_t;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sm_bus_ctrl_if #(.NUM_CPUS(N), .ID_W(IDW)) bus ();

  sm_bus_ctrl #(
    .NUM_CPUS    (N),
    .MEM_LATENCY (L),
    .ID_W        (IDW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  vec_t       tbl[$];
  logic [1:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic void v(input int t, input logic [1:0] wm, rm, wbk, io,
                            input logic [3:0] cs, input logic [1:0] fe, ii, gr,
                            input logic mr, mw, bsy, input logic [1:0] gid);
    vec_t r;
    r.tst    = 4'(t);
    r.i.wm   = wm;  r.i.rm = rm;  r.i.wbk = wbk;  r.i.io = io;  r.i.cs = cs;
    r.o.fe   = fe;  r.o.ii = ii;  r.o.gr = gr;
    r.o.mr   = mr;  r.o.mw = mw;  r.o.busy = bsy;
    r.o.gid  = gid; r.o.perr = 1'b0;
    tbl.push_back(r);
  endfunction

  function automatic out_t sample();
    out_t o;
    o.fe   = bus.fetch;     o.ii = bus.invalidateIn; o.gr = bus.grant;
    o.mr   = bus.memRead;   o.mw = bus.memWrite;     o.busy = bus.busy;
    o.gid  = bus.grantedId; o.perr = bus.protocolError;
    return o;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got fe=%b ii=%b gr=%b mr=%b mw=%b busy=%b gid=%0d perr=%b, expected fe=%b ii=%b gr=%b mr=%b mw=%b busy=%b gid=%0d perr=%b",
               name, act.fe, act.ii, act.gr, act.mr, act.mw, act.busy, act.gid, act.perr,
               exp.fe, exp.ii, exp.gr, exp.mr, exp.mw, exp.busy, exp.gid, exp.perr);
    end
  endtask

  task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    bus.writeMiss     = i.wm;
    bus.readMiss      = i.rm;
    bus.writeBack     = i.wbk;
    bus.invalidateOut = i.io;
    bus.cpuState      = i.cs;
  endtask

  // Wait (bounded) for any grant; pulses driven before the call last one cycle.
  task automatic wait_grant(output logic [1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      bus.readMiss = '0;
      #1;
      if (bus.grant != '0) begin
        g  = bus.grant;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    logic [1:0] e;
    bit         ok;
    bit         saw;

    // ---------------- cycle table ----------------
    // 1: readMiss[0], no owner -> 4 cycles memRead, grant 7 cycles later
    v(1, Z, 2'b01, Z, Z, 4'b0000, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    v(1, Z, Z, Z, Z, 4'b0000, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    v(1, Z, Z, Z, Z, 4'b0000, Z, Z, Z, 1'b0, 1'b0, 1'b1, 2'd0);
    repeat (4) v(1, Z, Z, Z, Z, 4'b0000, Z, Z, Z, 1'b1, 1'b0, 1'b1, 2'd0);
    v(1, Z, Z, Z, Z, 4'b0000, Z, Z, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0);
    v(1, Z, Z, Z, Z, 4'b0000, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    // 2: invalidateOut[0], both Shared -> invalidateIn[1], no memory
    v(2, Z, Z, Z, 2'b01, 4'b0101, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    v(2, Z, Z, Z, Z, 4'b0101, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    v(2, Z, Z, Z, Z, 4'b0101, Z, 2'b10, Z, 1'b0, 1'b0, 1'b1, 2'd0);
    v(2, Z, Z, Z, Z, 4'b0101, Z, Z, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0);
    v(2, Z, Z, Z, Z, 4'b0101, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    // 3: readMiss[1], CPU0 Modified -> fetch[0], write-back then read
    v(3, Z, 2'b10, Z, Z, 4'b0010, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    v(3, Z, Z, Z, Z, 4'b0010, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    v(3, Z, Z, Z, Z, 4'b0010, 2'b01, Z, Z, 1'b0, 1'b0, 1'b1, 2'd1);
    repeat (4) v(3, Z, Z, Z, Z, 4'b0010, Z, Z, Z, 1'b0, 1'b1, 1'b1, 2'd1);
    repeat (4) v(3, Z, Z, Z, Z, 4'b0010, Z, Z, Z, 1'b1, 1'b0, 1'b1, 2'd1);
    v(3, Z, Z, Z, Z, 4'b0010, Z, Z, 2'b10, 1'b0, 1'b0, 1'b1, 2'd1);
    v(3, Z, Z, Z, Z, 4'b0010, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd1);
    // 4: simultaneous upgrades; CPU0 first, CPU1's upgrade becomes a write miss
    v(4, Z, Z, Z, 2'b11, 4'b0101, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd1);
    v(4, Z, Z, Z, Z, 4'b0101, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd1);
    v(4, Z, Z, Z, Z, 4'b0101, Z, 2'b10, Z, 1'b0, 1'b0, 1'b1, 2'd0);
    v(4, Z, Z, Z, Z, 4'b0101, Z, Z, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0);
    v(4, Z, Z, Z, Z, 4'b0101, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd0);
    v(4, Z, Z, Z, Z, 4'b0101, Z, 2'b01, Z, 1'b0, 1'b0, 1'b1, 2'd1);
    repeat (4) v(4, Z, Z, Z, Z, 4'b0101, Z, Z, Z, 1'b1, 1'b0, 1'b1, 2'd1);
    v(4, Z, Z, Z, Z, 4'b0101, Z, Z, 2'b10, 1'b0, 1'b0, 1'b1, 2'd1);
    v(4, Z, Z, Z, Z, 4'b0101, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd1);
    // 5: writeMiss[1] with victim write-back, CPU0 Shared -> inv[0], wb, read
    v(5, 2'b10, Z, 2'b10, Z, 4'b0001, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd1);
    v(5, Z, Z, Z, Z, 4'b0001, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd1);
    v(5, Z, Z, Z, Z, 4'b0001, Z, 2'b01, Z, 1'b0, 1'b0, 1'b1, 2'd1);
    repeat (4) v(5, Z, Z, Z, Z, 4'b0001, Z, Z, Z, 1'b0, 1'b1, 1'b1, 2'd1);
    repeat (4) v(5, Z, Z, Z, Z, 4'b0001, Z, Z, Z, 1'b1, 1'b0, 1'b1, 2'd1);
    v(5, Z, Z, Z, Z, 4'b0001, Z, Z, 2'b10, 1'b0, 1'b0, 1'b1, 2'd1);
    v(5, Z, Z, Z, Z, 4'b0001, Z, Z, Z, 1'b0, 1'b0, 1'b0, 2'd1);

    // ---------------- reset ----------------
    reset = 1'b1;
    drive('0);
    #1;
    check_out("reset_state", sample(), '0);
    @(negedge clock);
    reset = 1'b0;

    // ---------------- table replay ----------------
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clock);
      drive(tbl[k].i);
      #1;
      check_out($sformatf("vec%0d_test%0d", k, tbl[k].tst), sample(), tbl[k].o);
    end

    // ---------------- fairness: 6 alternating grants ----------------
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    @(negedge clock);
    drive('0);
    bus.readMiss = 2'b11;
    for (int n = 0; n < 6; n++) begin
      wait_grant(g, ok);
      if (!ok) begin
        check_val($sformatf("fair_timeout%0d", n), 4'd0, 4'd1);
        break;
      end
      e = exp_q.pop_front();
      check_val($sformatf("fair_grant%0d", n), {2'b00, g}, 4'(2'b01 << e));
      if (n < 4) bus.readMiss[e] = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      bus.readMiss = '0;
      #1;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("fair_drained", {3'b000, ok}, 4'd1);

    // ---------------- protocol error, then reset mid-MEMRD ----------------
    @(negedge clock);
    bus.readMiss = 2'b01;
    @(negedge clock);
    bus.readMiss = 2'b01;
    @(negedge clock);
    bus.readMiss = 2'b00;
    #1;
    check_val("perr_set", {3'b000, bus.protocolError}, 4'd1);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.memRead) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    check_val("reach_memrd", {3'b000, ok}, 4'd1);
    @(negedge clock);
    #1;
    check_val("perr_sticky", {2'b00, bus.protocolError, bus.memRead}, 4'b0011);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", sample(), '0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      #1;
      if ((bus.grant != '0) || bus.busy || bus.memRead) saw = 1'b1;
    end
    check_val("no_grant_after_reset", {3'b000, saw}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
